fft_frame_collector: RTL

//  Receive end of the FFT output stream. Takes the 2-sample-per-cycle complex stream from the
//  FFT core's parallel-to-serial output. Assembles each 16-bin frame into a ping-pong buffer.

---
 rtl/fft_frame_collector_if.sv | 46 ++++
 rtl/fft_frame_collector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_collector_if.sv
// ============================================================================
// Module   : fft_frame_collector_if
// Purpose  : FFT output stream in, bin-serial handshake out. Optional out_mag
//            port is present when FFT_COLLECT_MAG_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fft_frame_collector_if #(
    parameter int DW = 17
);
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] data_i0_R;
    logic [DW-1:0] data_i0_I;
    logic [DW-1:0] data_i1_R;
    logic [DW-1:0] data_i1_I;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_R;
    logic [DW-1:0] out_I;
    logic [3:0]    out_idx;
    logic          out_last;
    logic          overflow;
`ifdef FFT_COLLECT_MAG_EN
    logic [DW:0]   out_mag;
`endif

    modport master (
        output in_valid, in_sof, data_i0_R, data_i0_I, data_i1_R, data_i1_I, out_ready,
        input  out_valid, out_R, out_I, out_idx, out_last, overflow
`ifdef FFT_COLLECT_MAG_EN
        , input out_mag
`endif
    );

    modport slave (
        input  in_valid, in_sof, data_i0_R, data_i0_I, data_i1_R, data_i1_I, out_ready,
        output out_valid, out_R, out_I, out_idx, out_last, overflow
`ifdef FFT_COLLECT_MAG_EN
        , output out_mag
`endif
    );
endinterface

`default_nettype wire

// File: rtl/fft_frame_collector.sv
// ============================================================================
// Module   : fft_frame_collector
// Purpose  : Collects 16-bin FFT frames (2 bins/beat) into a ping-pong buffer
//            and replays them one bin per cycle in natural order.
//            Define FFT_COLLECT_MAG_EN to add the out_mag L1-magnitude output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_frame_collector #(
    parameter int DW        = 17,
    parameter int N         = 16,
    parameter bit BITREV_IN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_frame_collector_if.slave bus
);

    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_FILL  = 1'b1;
    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_DRAIN = 1'b1;

    function automatic logic [3:0] f_bitrev4(input logic [3:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    // Two banks of N bins; bank status lives in full_q, so no reset is needed here
    logic [DW-1:0] mem_R_q [2][N];
    logic [DW-1:0] mem_I_q [2][N];

    logic [0:0]    wr_state_q, wr_state_d;
    logic [0:0]    rd_state_q, rd_state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_R_q, out_R_d;
    logic [DW-1:0] out_I_q, out_I_d;
    logic [3:0]    out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;

    logic          w_sof_beat;
    logic          w_we;
    logic [2:0]    w_beat;
    logic          w_fill_done;
    logic          w_ovf_set;
    logic [3:0]    w_pos0, w_pos1;
    logic [3:0]    w_addr0, w_addr1;

    logic          w_hs;
    logic          w_load;
    logic          w_load_bank;
    logic [3:0]    w_load_idx;
    logic          w_release;
    logic          w_go_idle;

    assign w_sof_beat = bus.in_valid & bus.in_sof;
    assign w_hs       = out_valid_q & bus.out_ready;

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_state_q <= W_IDLE;
        else     wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE: if (w_sof_beat && !full_q[wr_bank_q]) wr_state_d = W_FILL;
            W_FILL: if (bus.in_valid && !bus.in_sof && cnt_q == 3'd7) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        w_we        = 1'b0;
        w_beat      = cnt_q;
        cnt_d       = cnt_q;
        w_fill_done = 1'b0;
        w_ovf_set   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (w_sof_beat) begin
                    if (!full_q[wr_bank_q]) begin
                        w_we   = 1'b1;
                        w_beat = 3'd0;
                        cnt_d  = 3'd1;
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (bus.in_valid) begin
                    w_we = 1'b1;
                    // Early restart reuses the same bank from beat 0
                    if (bus.in_sof) begin
                        w_beat = 3'd0;
                        cnt_d  = 3'd1;
                    end else begin
                        cnt_d       = cnt_q + 3'd1;
                        w_fill_done = (cnt_q == 3'd7);
                    end
                end
            end
            default: ;
        endcase
    end

    assign w_pos0  = {w_beat, 1'b0};
    assign w_pos1  = {w_beat, 1'b1};
    assign w_addr0 = BITREV_IN ? f_bitrev4(w_pos0) : w_pos0;
    assign w_addr1 = BITREV_IN ? f_bitrev4(w_pos1) : w_pos1;

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_R_q[wr_bank_q][w_addr0] <= bus.data_i0_R;
            mem_I_q[wr_bank_q][w_addr0] <= bus.data_i0_I;
            mem_R_q[wr_bank_q][w_addr1] <= bus.data_i1_R;
            mem_I_q[wr_bank_q][w_addr1] <= bus.data_i1_I;
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_state_q <= R_IDLE;
        else     rd_state_q <= rd_state_d;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (full_q[rd_bank_q]) rd_state_d = R_DRAIN;
            R_DRAIN: if (w_hs && out_idx_q == 4'd15 && !full_q[~rd_bank_q]) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_load      = 1'b0;
        w_load_bank = rd_bank_q;
        w_load_idx  = 4'd0;
        w_release   = 1'b0;
        w_go_idle   = 1'b0;
        case (rd_state_q)
            R_IDLE: w_load = full_q[rd_bank_q];
            R_DRAIN: begin
                if (w_hs) begin
                    if (out_idx_q == 4'd15) begin
                        w_release = 1'b1;
                        // Chain straight into the other bank when it is already waiting
                        if (full_q[~rd_bank_q]) begin
                            w_load      = 1'b1;
                            w_load_bank = ~rd_bank_q;
                        end else begin
                            w_go_idle = 1'b1;
                        end
                    end else begin
                        w_load     = 1'b1;
                        w_load_idx = out_idx_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- shared state and output registers ----------------
    always_comb begin
        full_d = full_q;
        if (w_fill_done) full_d[wr_bank_q] = 1'b1;
        if (w_release)   full_d[rd_bank_q] = 1'b0;
        wr_bank_d  = w_fill_done ? ~wr_bank_q : wr_bank_q;
        rd_bank_d  = w_release ? ~rd_bank_q : rd_bank_q;
        overflow_d = overflow_q | w_ovf_set;

        out_valid_d = out_valid_q;
        out_R_d     = out_R_q;
        out_I_d     = out_I_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (w_load) begin
            out_valid_d = 1'b1;
            out_R_d     = mem_R_q[w_load_bank][w_load_idx];
            out_I_d     = mem_I_q[w_load_bank][w_load_idx];
            out_idx_d   = w_load_idx;
            out_last_d  = (w_load_idx == 4'd15);
        end else if (w_go_idle) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 3'd0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_R_q     <= '0;
            out_I_q     <= '0;
            out_idx_q   <= 4'd0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_R_q     <= out_R_d;
            out_I_q     <= out_I_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_R     = out_R_q;
    assign bus.out_I     = out_I_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.overflow  = overflow_q;

`ifdef FFT_COLLECT_MAG_EN
    function automatic logic [DW-1:0] f_abs(input logic [DW-1:0] v);
        return v[DW-1] ? ((~v) + DW'(1)) : v;
    endfunction

    logic [DW:0] out_mag_q, out_mag_d;

    assign out_mag_d = w_load ? ({1'b0, f_abs(out_R_d)} + {1'b0, f_abs(out_I_d)}) : out_mag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_mag_q <= '0;
        else     out_mag_q <= out_mag_d;
    end

    assign bus.out_mag = out_mag_q;
`endif

endmodule

`default_nettype wire
